// File: rtl/crc16_encode.sv
// USB transmit CRC16 generator: passes payload through, then appends the complemented CRC MSB-first.
// Optional CRC16_ENC_SELFCHECK_EN adds a receiver-side LFSR over the emitted stream to flag a bad residue.
module crc16_encode #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             stall,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [15:0]      crc_out,
  output logic [CNT_W-1:0] pld_bits,
  output logic             selfcheck_ok
);

  typedef enum logic [1:0] {IDLE, DATA, FLUSH} state_e;

  // x^16+x^15+x^2+1, MSB-out Galois form; identical to the receiver's LFSR
  function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic b);
    logic fb;
    fb = b ^ s[15];
    return {s[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      crc_q, crc_d;
  logic [CNT_W-1:0] pld_q, pld_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             accept;

  // start takes priority so an abort never lets a stale bit through
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    case (state_q)
      DATA: begin
        in_ready  = ~stall & ~start;
        out_valid = in_valid & ~stall & ~start;
        out_bit   = in_bit;
      end
      FLUSH: begin
        out_valid = ~stall & ~start;
        out_bit   = crc_q[4'd15 - cnt_q];
      end
      default: ;
    endcase
    accept   = (state_q == DATA) & in_valid & in_ready;
    out_last = (state_q == FLUSH) & out_valid & (cnt_q == 4'd15);
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    crc_d   = crc_q;
    pld_d   = pld_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (start) begin
      lfsr_d = 16'hFFFF;
      pld_d  = '0;
      cnt_d  = '0;
      if (in_last & ~in_valid) begin
        // zero-length packet: CRC of nothing is ~0xFFFF
        state_d = FLUSH;
        crc_d   = 16'h0000;
      end else begin
        state_d = DATA;
      end
    end else begin
      case (state_q)
        DATA: if (accept) begin
          lfsr_d = lfsr_step(lfsr_q, in_bit);
          pld_d  = (&pld_q) ? pld_q : pld_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (in_last) begin
            crc_d   = ~lfsr_d;
            state_d = FLUSH;
          end
        end
        FLUSH: if (~stall) begin
          if (cnt_q == 4'd15) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lfsr_q  <= 16'hFFFF;
      crc_q   <= 16'h0000;
      pld_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      crc_q   <= crc_d;
      pld_q   <= pld_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign crc_out  = crc_q;
  assign pld_bits = pld_q;

`ifdef CRC16_ENC_SELFCHECK_EN
  logic [15:0] chk_q, chk_d;
  logic        sc_q, sc_d;

  // a correct packet leaves the receiver LFSR at the fixed residue 0x800D
  always_comb begin
    chk_d = chk_q;
    sc_d  = sc_q;
    if (start)          chk_d = 16'hFFFF;
    else if (out_valid) chk_d = lfsr_step(chk_q, out_bit);
    if (done_q)         sc_d  = (chk_q == 16'h800D);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chk_q <= 16'hFFFF;
      sc_q  <= 1'b1;
    end else begin
      chk_q <= chk_d;
      sc_q  <= sc_d;
    end
  end

  assign selfcheck_ok = sc_q;
`else
  assign selfcheck_ok = 1'b1;
`endif

endmodule

// File: tb/tb_crc16_encode.sv
// Scoreboard bench for crc16_encode: expected stream queued at stimulus time, popped as out_valid bits appear.
module tb_crc16_encode;
  logic        clock = 1'b0;
  logic        reset_n, start, in_bit, in_valid, in_last, stall;
  logic        in_ready, out_bit, out_valid, out_last, busy, done, selfcheck_ok;
  logic [15:0] crc_out;
  logic [15:0] pld_bits;

  crc16_encode #(.CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .in_bit(in_bit),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready), .stall(stall),
    .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last), .busy(busy),
    .done(done), .crc_out(crc_out), .pld_bits(pld_bits), .selfcheck_ok(selfcheck_ok)
  );

  always #5 clock = ~clock;

  int          n_vec = 0, n_err = 0;
  int          cyc = 0;
  int          crc_seen = 0;
  int          done_cnt = 0;
  logic        stall_en = 1'b0;
  logic        exp_done = 1'b0;
  logic [15:0] rx_lfsr = 16'hFFFF;
  logic [1:0]  expq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mstep(input logic [15:0] s, input logic b);
    if (b ^ s[15]) return (s << 1) ^ 16'h8005;
    return s << 1;
  endfunction

  function automatic logic [15:0] crc_model(input logic [63:0] pl, input int n);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < n; i++) s = mstep(s, pl[i]);
    return ~s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    stall = stall_en && (cyc % 7 == 0);
  endtask

  // golden receiver and scoreboard consumer
  always @(negedge clock) begin
    if (!reset_n) begin
      rx_lfsr  = 16'hFFFF;
      crc_seen = 0;
      exp_done = 1'b0;
    end else begin
      if (done || exp_done) chk("done", 32'(done), 32'(exp_done));
      if (done) done_cnt++;
      exp_done = 1'b0;
      if (start) begin
        rx_lfsr  = 16'hFFFF;
        crc_seen = 0;
      end
      if (out_valid) begin
        if (expq.size() == 0) chk("extra_bit", 32'(1), 32'(0));
        else begin
          logic [1:0] e;
          e = expq.pop_front();
          chk("out_bit", 32'(out_bit), 32'(e[1]));
          chk("out_last", 32'(out_last), 32'(e[0]));
          if (e[0]) exp_done = 1'b1;
        end
        rx_lfsr = mstep(rx_lfsr, out_bit);
        if (!in_ready) crc_seen++;
      end
    end
  end

  task automatic send(input logic [63:0] pl, input int n, input int abort_at,
                      input int rst_at, input logic flip);
    logic [15:0] crc, sent;
    int m, i, guard, d0;
    logic s;
    crc  = crc_model(pl, n);
    sent = flip ? (crc ^ 16'h0008) : crc;
    m    = (abort_at > 0) ? abort_at : n;
    for (int k = 0; k < m; k++) expq.push_back({pl[k], 1'b0});
    if (abort_at == 0)
      for (int k = 15; k >= 0; k--) expq.push_back({sent[k], k == 0});
    d0 = done_cnt;
    start = 1'b1; in_last = (n == 0); in_valid = 1'b0;
    tick();
    start = 1'b0; in_last = 1'b0;
    i = 0; guard = 0;
    while (i < m && guard < 1000) begin
      in_valid = 1'b1; in_bit = pl[i]; in_last = (i == n - 1);
      s = stall;
      tick();
      if (!s) i++;
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_bit = 1'b0;
    if (guard >= 1000) chk("accept_timeout", 32'(guard), 32'(0));
    if (abort_at > 0) return;
`ifdef CRC16_ENC_SELFCHECK_EN
    if (flip) force dut.crc_q = sent;
`endif
    guard = 0;
    while (done_cnt == d0 && guard < 200) begin
      if (rst_at >= 0 && crc_seen == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_crc_out", 32'(crc_out), 32'(0));
        chk("rst_pld_bits", 32'(pld_bits), 32'(0));
        chk("rst_selfcheck", 32'(selfcheck_ok), 32'(1));
        expq.delete();
        tick();
        reset_n = 1'b1;
        tick();
        return;
      end
      tick();
      guard++;
    end
    if (guard >= 200) chk("done_timeout", 32'(guard), 32'(0));
    tick();
`ifdef CRC16_ENC_SELFCHECK_EN
    if (flip) release dut.crc_q;
    chk("selfcheck_ok", 32'(selfcheck_ok), 32'(!flip));
`else
    chk("selfcheck_ok", 32'(selfcheck_ok), 32'(1));
`endif
    chk("crc_out", 32'(crc_out), 32'(sent));
    chk("pld_bits", 32'(pld_bits), 32'(n));
    if (!flip) chk("rx_residue", 32'(rx_lfsr), 32'h800D);
    chk("queue_empty", 32'(expq.size()), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    logic [63:0] r;
    reset_n = 1'b0; start = 1'b0; in_bit = 1'b0; in_valid = 1'b0;
    in_last = 1'b0; stall = 1'b0;
    #12;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_crc_out", 32'(crc_out), 32'(0));
    chk("reset_pld_bits", 32'(pld_bits), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_selfcheck", 32'(selfcheck_ok), 32'(1));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    reset_n = 1'b1;
    tick(); tick();

    // IDLE ignores in_valid and stall
    in_valid = 1'b1; stall = 1'b1;
    #1 chk("idle_in_ready", 32'(in_ready), 32'(0));
    chk("idle_out_valid", 32'(out_valid), 32'(0));
    tick();
    in_valid = 1'b0; stall = 1'b0;

    send(64'h0, 0, 0, -1, 1'b0);                   // zero-length
    send(64'h0, 8, 0, -1, 1'b0);                   // one byte 0x00
    send(64'hA5, 8, 0, -1, 1'b0);
    r = {$urandom, $urandom};
    send(r, 64, 0, -1, 1'b0);
    stall_en = 1'b1;
    send(r, 64, 0, -1, 1'b0);                      // same payload, stalled
    send({$urandom, $urandom}, 40, 20, -1, 1'b0);  // aborted at bit 20
    send(64'hBEEF, 16, 0, -1, 1'b0);
    send({$urandom, $urandom}, 33, 0, 9, 1'b0);    // reset at flush cnt 9
    send(64'h1234_5678, 32, 0, -1, 1'b0);
`ifdef CRC16_ENC_SELFCHECK_EN
    send(64'hC3, 8, 0, -1, 1'b1);                  // corrupted CRC bit 3
    send(64'h3C, 8, 0, -1, 1'b0);
`endif
    stall_en = 1'b0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
